// File: rtl/wb_uart_pkg.sv
// Shared UART definitions: register offsets, STATUS/CTRL bit positions, FSM encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_defs;

    // Register offsets, decoded from wb_adr_i[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    // STATUS bit positions
    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_RX_OVR    = 3;
    localparam int ST_FRAME_ERR = 4;
    localparam int ST_TX_OVF    = 5;
    localparam int ST_TX_BUSY   = 6;

    // CTRL bit positions
    localparam int CTRL_TX_IRQ_EN = 0;
    localparam int CTRL_RX_IRQ_EN = 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // A bit period shorter than two clocks leaves no room for a mid-bit sample.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction

endpackage

// File: rtl/wb_uart_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// Latency: a pushed word is visible on o_pop_dat / o_empty the cycle after the push.
// Backpressure: pushes while full are ignored unless a pop happens in the same cycle.
// Ports: i_clk/i_rst clock and sync reset; i_push/i_push_dat write side;
//        i_pop/o_pop_dat read side; o_full/o_empty occupancy flags.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/wb_uart.sv
// Wishbone UART: DATA/STATUS/CTRL/DIV registers, TX FIFO + serializer, RX deserializer.
// Latency: ack one cycle after cyc&stb; TX frame starts two cycles after the DATA write ack.
// Backpressure: none on the bus; DATA writes into a full TX FIFO are dropped and flagged.
// Ports: wb_* Wishbone slave (clock wb_clk_i, sync active-high wb_rst_i);
//        uart_txd_o/uart_rxd_i serial line; uart_int_o level interrupt.
module wb_uart
    import uart_defs::*;
#(
    parameter int CLK_DIV_RST = 868,
    parameter int TX_DEPTH    = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        uart_txd_o,
    input  logic        uart_rxd_i,
    output logic        uart_int_o
);
    // Bus and register state
    logic        r_ack, r_rx_valid, r_rx_ovr, r_frame_err, r_tx_ovf, r_int;
    logic [1:0]  r_ctrl;
    logic [15:0] r_div;
    logic [7:0]  r_rx_byte;
    logic [31:0] w_rd_dat;
    logic [1:0]  w_reg;
    logic        w_req, w_acc, w_wr, w_data_wr, w_data_rd, w_stat_rd, w_unused;
    logic [15:0] w_div_m1, w_half_m1;

    // TX path
    tx_state_t   r_tx_state, w_tx_state_nxt;
    logic [15:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]  r_tx_bit, w_tx_bit_nxt;
    logic [7:0]  r_tx_shift, w_tx_shift_nxt, w_fifo_dat;
    logic        r_txd, w_txd_nxt, w_tx_pop, w_tx_load, w_fifo_full, w_fifo_empty, w_tx_busy;

    // RX path
    rx_state_t   r_rx_state, w_rx_state_nxt;
    logic [15:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]  r_rx_bit, w_rx_bit_nxt;
    logic [7:0]  r_rx_shift, w_rx_shift_nxt;
    logic        r_rx_s1, r_rx_s2, r_rx_prev, w_rx_done, w_rx_ferr;

    assign w_unused  = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};
    assign w_reg     = wb_adr_i[3:2];
    // r_ack masks the request for one cycle so a held strobe is acked exactly once.
    assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_acc     = r_ack & wb_cyc_i & wb_stb_i;
    assign w_wr      = w_acc & wb_we_i;
    assign w_data_wr = w_wr & (w_reg == REG_DATA) & wb_sel_i[0];
    assign w_data_rd = w_acc & ~wb_we_i & (w_reg == REG_DATA);
    assign w_stat_rd = w_acc & ~wb_we_i & (w_reg == REG_STATUS);
    assign w_div_m1  = eff_div(r_div) - 16'd1;
    assign w_half_m1 = (eff_div(r_div) >> 1) - 16'd1;
    assign w_tx_busy = (r_tx_state != TX_IDLE);

    assign wb_ack_o   = r_ack;
    assign wb_dat_o   = (r_ack & ~wb_we_i) ? w_rd_dat : '0;
    assign uart_txd_o = r_txd;
    assign uart_int_o = r_int;

    always_comb begin
        w_rd_dat = '0;
        case (w_reg)
            REG_DATA:   w_rd_dat = r_rx_valid ? {24'b0, r_rx_byte} : '0;
            REG_STATUS: begin
                w_rd_dat[ST_TX_FULL]   = w_fifo_full;
                w_rd_dat[ST_TX_EMPTY]  = w_fifo_empty;
                w_rd_dat[ST_RX_VALID]  = r_rx_valid;
                w_rd_dat[ST_RX_OVR]    = r_rx_ovr;
                w_rd_dat[ST_FRAME_ERR] = r_frame_err;
                w_rd_dat[ST_TX_OVF]    = r_tx_ovf;
                w_rd_dat[ST_TX_BUSY]   = w_tx_busy;
            end
            REG_CTRL:   w_rd_dat = {30'b0, r_ctrl};
            default:    w_rd_dat = {16'b0, r_div};
        endcase
    end

    uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_clk      (wb_clk_i),
        .i_rst      (wb_rst_i),
        .i_push     (w_data_wr),
        .i_push_dat (wb_dat_i[7:0]),
        .i_pop      (w_tx_pop),
        .o_pop_dat  (w_fifo_dat),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    // TX serializer: each state holds for one bit period, counted down in r_tx_cnt.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt - 16'd1;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_load      = 1'b0;
        case (r_tx_state)
            TX_IDLE:  w_tx_load = ~w_fifo_empty;
            TX_START: if (r_tx_cnt == 16'd0) begin
                w_tx_state_nxt = TX_DATA;
                w_tx_cnt_nxt   = w_div_m1;
                w_tx_bit_nxt   = 3'd0;
            end
            TX_DATA:  if (r_tx_cnt == 16'd0) begin
                w_tx_cnt_nxt = w_div_m1;
                if (r_tx_bit == 3'd7) begin
                    w_tx_state_nxt = TX_STOP;
                end else begin
                    w_tx_bit_nxt   = r_tx_bit + 3'd1;
                    w_tx_shift_nxt = r_tx_shift >> 1;
                end
            end
            default:  if (r_tx_cnt == 16'd0) begin
                // Chain straight into the next frame so back-to-back bytes have no idle gap.
                w_tx_load      = ~w_fifo_empty;
                w_tx_state_nxt = TX_IDLE;
            end
        endcase
        if (r_tx_state == TX_IDLE && !w_tx_load) w_tx_cnt_nxt = r_tx_cnt;
        if (w_tx_load) begin
            w_tx_state_nxt = TX_START;
            w_tx_cnt_nxt   = w_div_m1;
            w_tx_shift_nxt = w_fifo_dat;
        end
        w_tx_pop = w_tx_load;
        case (w_tx_state_nxt)
            TX_START: w_txd_nxt = 1'b0;
            TX_DATA:  w_txd_nxt = w_tx_shift_nxt[0];
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    // RX deserializer: half a bit after the falling edge lands mid-start-bit,
    // then full bit periods land mid-bit for the data and stop bits.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt - 16'd1;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_done      = 1'b0;
        w_rx_ferr      = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt = r_rx_cnt;
                if (r_rx_prev & ~r_rx_s2) begin
                    w_rx_state_nxt = RX_START;
                    w_rx_cnt_nxt   = w_half_m1;
                end
            end
            RX_START: if (r_rx_cnt == 16'd0) begin
                // A high start sample means the edge was a glitch.
                w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
                w_rx_cnt_nxt   = w_div_m1;
                w_rx_bit_nxt   = 3'd0;
            end
            RX_DATA: if (r_rx_cnt == 16'd0) begin
                w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
                w_rx_cnt_nxt   = w_div_m1;
                w_rx_bit_nxt   = r_rx_bit + 3'd1;
                if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
            end
            default: if (r_rx_cnt == 16'd0) begin
                w_rx_state_nxt = RX_IDLE;
                w_rx_done      = r_rx_s2;
                w_rx_ferr      = ~r_rx_s2;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1    <= uart_rxd_i;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack       <= 1'b0;
            r_ctrl      <= '0;
            r_div       <= 16'(CLK_DIV_RST);
            r_rx_byte   <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_ovr    <= 1'b0;
            r_frame_err <= 1'b0;
            r_tx_ovf    <= 1'b0;
            r_int       <= 1'b0;
        end else begin
            r_ack <= w_req;
            if (w_wr && w_reg == REG_CTRL && wb_sel_i[0]) r_ctrl <= wb_dat_i[1:0];
            if (w_wr && w_reg == REG_DIV) begin
                if (wb_sel_i[0]) r_div[7:0]  <= wb_dat_i[7:0];
                if (wb_sel_i[1]) r_div[15:8] <= wb_dat_i[15:8];
            end
            // Clear-on-read first so an event in the same cycle is not lost.
            if (w_stat_rd) begin
                r_rx_ovr    <= 1'b0;
                r_frame_err <= 1'b0;
                r_tx_ovf    <= 1'b0;
            end
            if (w_data_wr && w_fifo_full && !w_tx_pop) r_tx_ovf <= 1'b1;
            if (w_rx_ferr) r_frame_err <= 1'b1;
            // A DATA read in the landing cycle consumes the old byte, so no overrun.
            if (w_rx_done) begin
                r_rx_byte  <= r_rx_shift;
                r_rx_valid <= 1'b1;
                if (r_rx_valid && !w_data_rd) r_rx_ovr <= 1'b1;
            end else if (w_data_rd) begin
                r_rx_valid <= 1'b0;
            end
            r_int <= (r_ctrl[CTRL_TX_IRQ_EN] & w_fifo_empty & ~w_tx_busy) |
                     (r_ctrl[CTRL_RX_IRQ_EN] & r_rx_valid);
        end
    end

endmodule

// File: tb/tb_wb_uart.sv
// Directed + randomized bench for wb_uart with a reference model of the register file.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_uart;
    logic        wb_clk_i, wb_rst_i, wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o, uart_txd_o, uart_rxd_i, uart_int_o;

    wb_uart #(.CLK_DIV_RST(868), .TX_DEPTH(8)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .uart_txd_o (uart_txd_o),
        .uart_rxd_i (uart_rxd_i),
        .uart_int_o (uart_int_o)
    );

    localparam int LOG = 8192;
    localparam int DIV = 4;

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Per-cycle record of the serial line for frame reconstruction.
    logic line_log [LOG];
    int   cyc_cnt = 0;
    always @(negedge wb_clk_i) begin
        if (cyc_cnt < LOG) line_log[cyc_cnt] <= uart_txd_o;
        cyc_cnt <= cyc_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic       m_valid, m_ovr, m_ferr, m_tx_ovf;
    logic [7:0] m_byte;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_ovr = 0; m_ferr = 0; m_tx_ovf = 0; m_byte = 0;
    endtask

    task automatic model_rx(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok) begin
            m_ferr = 1;
        end else begin
            if (m_valid) m_ovr = 1;
            m_byte  = b;
            m_valid = 1;
        end
    endtask

    // STATUS as seen while the transmitter is idle and drained.
    function automatic logic [31:0] model_status_idle();
        return {25'b0, 1'b0, m_tx_ovf, m_ferr, m_ovr, m_valid, 1'b1, 1'b0};
    endfunction

    task automatic wb_xfer(input logic we, input logic [3:0] off, input logic [31:0] dat,
                           output logic [31:0] rd);
        int   waited;
        logic got;
        rd = 'x;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we;
        wb_adr_i = {28'b0, off}; wb_dat_i = dat; wb_sel_i = 4'hF;
        got = 0; waited = 0;
        while (!got && waited < 16) begin
            @(negedge wb_clk_i);
            waited++;
            if (wb_ack_o) begin
                got = 1;
                rd  = wb_dat_o;
            end
        end
        check("ack_seen", 64'(got), 64'd1);
        check("ack_latency", 64'(waited), 64'd1);
        @(posedge wb_clk_i);
        #1;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        @(negedge wb_clk_i);
        check("ack_one_cycle", 64'(wb_ack_o), 64'd0);
        check("dat_o_idle_zero", 64'(wb_dat_o), 64'd0);
    endtask

    task automatic wb_write(input logic [3:0] off, input logic [31:0] dat);
        logic [31:0] rd;
        wb_xfer(1'b1, off, dat, rd);
    endtask

    task automatic read_check(input string tag, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(1'b0, off, 32'h0, rd);
        check(tag, 64'(rd), 64'(exp));
    endtask

    task automatic status_check(input string tag);
        read_check(tag, 4'h4, model_status_idle());
        m_ovr = 0; m_ferr = 0; m_tx_ovf = 0;
    endtask

    task automatic data_check(input string tag);
        read_check(tag, 4'h0, m_valid ? {24'b0, m_byte} : 32'h0);
        m_valid = 0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd_i = f[i];
            repeat (DIV) @(negedge wb_clk_i);
        end
        uart_rxd_i = 1;
        repeat (8) @(negedge wb_clk_i);
    endtask

    // Rebuilds each 10-bit frame (DIV clocks per bit) from the line log.
    task automatic check_tx(input string tag, input int from, input logic [7:0] q[$]);
        int          idx;
        logic        found;
        logic [39:0] obs, exp;
        logic [7:0]  b;
        found = 0; idx = from;
        for (int k = from; k < cyc_cnt && k < LOG && !found; k++) begin
            if (line_log[k] == 1'b0) begin
                found = 1;
                idx   = k;
            end
        end
        check({tag, "_start_found"}, 64'(found), 64'd1);
        if (found) begin
            for (int j = 0; j < q.size(); j++) begin
                b = q[j];
                for (int i = 0; i < 40; i++) begin
                    exp[i] = (i < 4) ? 1'b0 : (i < 36) ? b[(i - 4) / 4] : 1'b1;
                    obs[i] = (idx + 40 * j + i < LOG) ? line_log[idx + 40 * j + i] : 1'bx;
                end
                check(tag, 64'(obs), 64'(exp));
            end
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] lead, rb;
        logic       ack_seen;
        int         from;

        wb_rst_i = 1; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0; uart_rxd_i = 1;
        model_reset();
        repeat (3) @(negedge wb_clk_i);
        check("rst_ack", 64'(wb_ack_o), 64'd0);
        check("rst_dat_o", 64'(wb_dat_o), 64'd0);
        check("rst_txd", 64'(uart_txd_o), 64'd1);
        check("rst_int", 64'(uart_int_o), 64'd0);
        wb_rst_i = 0;
        @(negedge wb_clk_i);
        status_check("rst_status");
        read_check("rst_div", 4'hC, 32'd868);
        read_check("rst_ctrl", 4'h8, 32'd0);

        // DIV keeps only its low 16 bits
        wb_write(4'hC, 32'h1234_5678);
        read_check("div_16bit", 4'hC, 32'h0000_5678);
        wb_write(4'hC, DIV);
        read_check("div_4", 4'hC, DIV);

        // Single frame 0x55
        from = cyc_cnt;
        wb_write(4'h0, 32'h55);
        repeat (60) @(negedge wb_clk_i);
        q = {8'h55};
        check_tx("tx_55", from, q);
        status_check("tx_55_status");

        // TX-empty interrupt
        wb_write(4'h8, 32'h1);
        repeat (2) @(negedge wb_clk_i);
        check("tx_irq", 64'(uart_int_o), 64'd1);
        wb_write(4'h8, 32'h2);
        repeat (2) @(negedge wb_clk_i);
        check("tx_irq_off", 64'(uart_int_o), 64'd0);

        // A random lead byte occupies the serializer while 0x01..0x09 are written:
        // eight fill the FIFO, the ninth is dropped.
        lead = 8'($urandom_range(0, 255));
        from = cyc_cnt;
        wb_write(4'h0, {24'b0, lead});
        for (int i = 1; i <= 9; i++) wb_write(4'h0, 32'(i));
        read_check("ovf_status", 4'h4, 32'h61);
        repeat (9 * 40 + 40) @(negedge wb_clk_i);
        q = {lead};
        for (int i = 1; i <= 8; i++) q.push_back(8'(i));
        check_tx("tx_burst", from, q);
        status_check("ovf_cleared");

        // RX 0xA3 with rx interrupt enabled
        rx_frame(8'hA3, 1'b1);
        model_rx(8'hA3, 1'b1);
        status_check("rx_a3_status");
        check("rx_irq", 64'(uart_int_o), 64'd1);
        data_check("rx_a3_data");
        repeat (2) @(negedge wb_clk_i);
        check("rx_irq_clear", 64'(uart_int_o), 64'd0);
        status_check("rx_a3_consumed");

        // Overrun
        rx_frame(8'h11, 1'b1); model_rx(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1); model_rx(8'h22, 1'b1);
        data_check("ovr_data");
        status_check("ovr_status");
        status_check("ovr_cleared");

        // Random byte
        rb = 8'($urandom_range(0, 255));
        rx_frame(rb, 1'b1); model_rx(rb, 1'b1);
        data_check("rx_rand_data");

        // Stop bit low
        rb = 8'($urandom_range(0, 255));
        rx_frame(rb, 1'b0); model_rx(rb, 1'b0);
        status_check("ferr_status");
        status_check("ferr_cleared");

        // One-clock glitch
        uart_rxd_i = 0;
        @(negedge wb_clk_i);
        uart_rxd_i = 1;
        repeat (40) @(negedge wb_clk_i);
        status_check("glitch_status");

        // Reset mid-frame with a read pending
        wb_write(4'h0, 32'h00);
        repeat (10) @(negedge wb_clk_i);
        check("midframe_low", 64'(uart_txd_o), 64'd0);
        wb_rst_i = 1;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h4;
        @(negedge wb_clk_i);
        check("rst_mid_txd", 64'(uart_txd_o), 64'd1);
        check("rst_mid_dat_o", 64'(wb_dat_o), 64'd0);
        ack_seen = wb_ack_o;
        repeat (3) begin
            @(negedge wb_clk_i);
            ack_seen = ack_seen | wb_ack_o;
        end
        check("rst_no_ack", 64'(ack_seen), 64'd0);
        wb_cyc_i = 0; wb_stb_i = 0;
        @(negedge wb_clk_i);
        wb_rst_i = 0;
        model_reset();
        @(negedge wb_clk_i);
        check("rst_mid_int", 64'(uart_int_o), 64'd0);
        status_check("rst_mid_status");
        read_check("rst_mid_div", 4'hC, 32'd868);
        read_check("rst_mid_ctrl", 4'h8, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
